// File: rtl/cube_pkg.sv
// Shared constants and job encoding for the cube engine scan scheduler.
package cube_pkg;

    localparam int NUM_CUBES = 50;
    localparam int SWEEP_LEN = 51;

    localparam logic [10:0] PARK_X     = 11'h7FF;
    localparam logic [9:0]  PARK_Y     = 10'h3FF;
    localparam logic [5:0]  PHASE_LAST = 6'(SWEEP_LEN - 1);

    localparam logic GS_COLLIDE = 1'b0;
    localparam logic GS_EXPLODE = 1'b1;
    localparam logic ID_SHELL   = 1'b0;
    localparam logic ID_PLAYER  = 1'b1;

    typedef enum logic [1:0] {
        JOB_NONE    = 2'd0,
        JOB_PLAYER  = 2'd1,
        JOB_SHELL   = 2'd2,
        JOB_EXPLODE = 2'd3
    } job_t;

    // Bit positions inside the 4-bit object-state result.
    localparam int RES_RIGHT   = 0;
    localparam int RES_LEFT    = 1;
    localparam int RES_SUPPORT = 2;
    localparam int RES_UP      = 3;

endpackage

// File: rtl/cube_scan_sched_if.sv
// Requester-side bundle of the scan scheduler: player and shell collision slots plus the explode slot.
interface cube_scan_sched_if;

    logic        p_req_valid;
    logic        p_req_ready;
    logic [10:0] p_req_x;
    logic [9:0]  p_req_y;
    logic        p_rsp_valid;
    logic [3:0]  p_rsp_states;

    logic        s_req_valid;
    logic        s_req_ready;
    logic [10:0] s_req_x;
    logic [9:0]  s_req_y;
    logic        s_rsp_valid;
    logic [3:0]  s_rsp_states;

    logic        e_req_valid;
    logic        e_req_ready;
    logic [10:0] e_req_x;
    logic [9:0]  e_req_y;
    logic        e_done;

    modport master (
        output p_req_valid, p_req_x, p_req_y,
        output s_req_valid, s_req_x, s_req_y,
        output e_req_valid, e_req_x, e_req_y,
        input  p_req_ready, p_rsp_valid, p_rsp_states,
        input  s_req_ready, s_rsp_valid, s_rsp_states,
        input  e_req_ready, e_done
    );

    modport slave (
        input  p_req_valid, p_req_x, p_req_y,
        input  s_req_valid, s_req_x, s_req_y,
        input  e_req_valid, e_req_x, e_req_y,
        output p_req_ready, p_rsp_valid, p_rsp_states,
        output s_req_ready, s_rsp_valid, s_rsp_states,
        output e_req_ready, e_done
    );

endinterface

// File: rtl/cube_req_slot.sv
// One-deep request latch: accepts a coordinate when free and holds it until the arbiter grants it.
module cube_req_slot
    import cube_pkg::*;
(
    input  logic        clock,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [10:0] req_x,
    input  logic [9:0]  req_y,
    input  logic        grant,
    output logic        pending,
    output logic [10:0] x,
    output logic [9:0]  y
);

    assign req_ready = !pending;

    // A grant frees the slot; a new request can only land once the slot is free.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pending <= 1'b0;
            x       <= PARK_X;
            y       <= PARK_Y;
        end else if (grant) begin
            pending <= 1'b0;
        end else if (req_valid && !pending) begin
            pending <= 1'b1;
            x       <= req_x;
            y       <= req_y;
        end
    end

endmodule

// File: rtl/cube_scan_sched.sv
// Sweep-aligned scheduler sharing the cube engine between player/shell collision and explode jobs.
// Explode results are folded into an authoritative alive bitmap, since the engine rewrites survivors.
//
// job          | meaning
// JOB_NONE     | idle sweep, engine parked off-field in collide mode
// JOB_PLAYER   | player collision sweep, result to p_rsp_*
// JOB_SHELL    | shell collision sweep, result to s_rsp_*
// JOB_EXPLODE  | explode sweep, cube results ANDed into cube_alive
module cube_scan_sched
    import cube_pkg::*;
(
    input  logic                 clock,
    input  logic                 rst_n,
    cube_scan_sched_if.slave     req,
    output logic                 eng_game_state,
    output logic                 eng_id,
    output logic [10:0]          eng_x,
    output logic [9:0]           eng_y,
    input  logic [3:0]           eng_states_in,
    input  logic [NUM_CUBES-1:0] eng_cubes_in,
    output logic [NUM_CUBES-1:0] cube_alive
);

    logic [5:0]  phase;
    logic        boundary;
    logic        capture;

    logic        p_pend, s_pend, e_pend;
    logic        p_grant, s_grant, e_grant;
    logic [10:0] p_x, s_x, e_x;
    logic [9:0]  p_y, s_y, e_y;

    job_t        active_job, active_next, cap_job;
    logic        rr, rr_next;
    logic        gs_next, id_next;
    logic [10:0] x_next;
    logic [9:0]  y_next;

    logic        p_rsp_valid, s_rsp_valid, e_done;
    logic [3:0]  p_rsp_states, s_rsp_states;

    assign boundary = (phase == PHASE_LAST);
    assign capture  = (phase == 6'd0);

    cube_req_slot u_p_slot (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req.p_req_valid),
        .req_ready (req.p_req_ready),
        .req_x     (req.p_req_x),
        .req_y     (req.p_req_y),
        .grant     (p_grant),
        .pending   (p_pend),
        .x         (p_x),
        .y         (p_y)
    );

    cube_req_slot u_s_slot (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req.s_req_valid),
        .req_ready (req.s_req_ready),
        .req_x     (req.s_req_x),
        .req_y     (req.s_req_y),
        .grant     (s_grant),
        .pending   (s_pend),
        .x         (s_x),
        .y         (s_y)
    );

    cube_req_slot u_e_slot (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req.e_req_valid),
        .req_ready (req.e_req_ready),
        .req_x     (req.e_req_x),
        .req_y     (req.e_req_y),
        .grant     (e_grant),
        .pending   (e_pend),
        .x         (e_x),
        .y         (e_y)
    );

    // rr = 0 prefers player, rr = 1 prefers shell; explode always wins.
    always_comb begin
        active_next = JOB_NONE;
        rr_next     = rr;
        gs_next     = GS_COLLIDE;
        id_next     = ID_SHELL;
        x_next      = PARK_X;
        y_next      = PARK_Y;
        if (e_pend) begin
            active_next = JOB_EXPLODE;
            gs_next     = GS_EXPLODE;
            x_next      = e_x;
            y_next      = e_y;
        end else if (p_pend && (!s_pend || !rr)) begin
            active_next = JOB_PLAYER;
            id_next     = ID_PLAYER;
            x_next      = p_x;
            y_next      = p_y;
            rr_next     = 1'b1;
        end else if (s_pend) begin
            active_next = JOB_SHELL;
            x_next      = s_x;
            y_next      = s_y;
            rr_next     = 1'b0;
        end
    end

    assign p_grant = boundary && (active_next == JOB_PLAYER);
    assign s_grant = boundary && (active_next == JOB_SHELL);
    assign e_grant = boundary && (active_next == JOB_EXPLODE);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            phase          <= 6'd0;
            active_job     <= JOB_NONE;
            cap_job        <= JOB_NONE;
            rr             <= 1'b0;
            eng_game_state <= GS_COLLIDE;
            eng_id         <= ID_SHELL;
            eng_x          <= PARK_X;
            eng_y          <= PARK_Y;
            p_rsp_valid    <= 1'b0;
            s_rsp_valid    <= 1'b0;
            e_done         <= 1'b0;
            p_rsp_states   <= 4'd0;
            s_rsp_states   <= 4'd0;
            cube_alive     <= '1;
        end else begin
            phase       <= boundary ? 6'd0 : phase + 6'd1;
            p_rsp_valid <= 1'b0;
            s_rsp_valid <= 1'b0;
            e_done      <= 1'b0;
            if (boundary) begin
                active_job     <= active_next;
                cap_job        <= active_job;
                rr             <= rr_next;
                eng_game_state <= gs_next;
                eng_id         <= id_next;
                eng_x          <= x_next;
                eng_y          <= y_next;
            end
            // Engine latched its results on the previous (boundary) edge.
            if (capture) begin
                case (cap_job)
                    JOB_PLAYER: begin
                        p_rsp_valid  <= 1'b1;
                        p_rsp_states <= eng_states_in;
                    end
                    JOB_SHELL: begin
                        s_rsp_valid  <= 1'b1;
                        s_rsp_states <= eng_states_in;
                    end
                    JOB_EXPLODE: begin
                        cube_alive <= cube_alive & eng_cubes_in;
                        e_done     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req.p_rsp_valid  = p_rsp_valid;
    assign req.p_rsp_states = p_rsp_states;
    assign req.s_rsp_valid  = s_rsp_valid;
    assign req.s_rsp_states = s_rsp_states;
    assign req.e_done       = e_done;

endmodule

// File: tb/tb_cube_scan_sched.sv
// Bench for cube_scan_sched: behavioural engine model, directed job table and multi-sweep sequences.
module tb_cube_scan_sched;
    import cube_pkg::*;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    cube_scan_sched_if bus ();

    logic                 eng_game_state, eng_id;
    logic [10:0]          eng_x;
    logic [9:0]           eng_y;
    logic [3:0]           eng_states_in = 4'd0;
    logic [NUM_CUBES-1:0] eng_cubes_in  = '0;
    logic [NUM_CUBES-1:0] cube_alive;

    cube_scan_sched dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .req            (bus),
        .eng_game_state (eng_game_state),
        .eng_id         (eng_id),
        .eng_x          (eng_x),
        .eng_y          (eng_y),
        .eng_states_in  (eng_states_in),
        .eng_cubes_in   (eng_cubes_in),
        .cube_alive     (cube_alive)
    );

    typedef struct {
        logic        sh;
        logic [10:0] x;
        logic [9:0]  y;
        int          ph;
        logic [3:0]  st;
        int          wt;
    } vec_t;

    typedef struct {
        int         kind;
        int         cyc;
        logic [3:0] st;
    } rsp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   hold_err = 0;
    rsp_t rlog[$];
    logic [5:0]  tb_phase   = 6'd0;
    logic [23:0] prev_eng   = '0;
    logic        prev_rst   = 1'b0;
    logic [5:0]  prev_phase = 6'd0;

    // Engine cube i sits at x = (i%10)*64+32, y = (i/10)*128+64; blast reaches +/-64 on each axis.
    function automatic logic [NUM_CUBES-1:0] blast(input logic [10:0] x, input logic [9:0] y);
        logic [NUM_CUBES-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_CUBES; i++) begin
            int dx, dy;
            dx = (i % 10) * 64 + 32 - int'(x);
            dy = (i / 10) * 128 + 64 - int'(y);
            if (dx <= 64 && dx >= -64 && dy <= 64 && dy >= -64) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Engine model: own phase counter, results latched on its phase-50 edge.
    always @(posedge clock) begin
        if (!rst_n) begin
            tb_phase      <= 6'd0;
            eng_states_in <= 4'd0;
            eng_cubes_in  <= '0;
        end else begin
            tb_phase <= (tb_phase == 6'd50) ? 6'd0 : tb_phase + 6'd1;
            if (tb_phase == 6'd50) begin
                eng_states_in <= eng_x[3:0] ^ eng_y[3:0] ^ {eng_id, 3'b000};
                eng_cubes_in  <= eng_game_state ? ~blast(eng_x, eng_y) : '0;
            end
        end
    end

    always @(posedge clock) begin
        cyc        <= cyc + 1;
        prev_eng   <= {eng_game_state, eng_id, eng_x, eng_y};
        prev_rst   <= rst_n;
        prev_phase <= tb_phase;
        if (prev_rst && prev_phase != 6'd50 && {eng_game_state, eng_id, eng_x, eng_y} != prev_eng)
            hold_err <= hold_err + 1;
        if (bus.p_rsp_valid) rlog.push_back('{0, cyc, bus.p_rsp_states});
        if (bus.s_rsp_valid) rlog.push_back('{1, cyc, bus.s_rsp_states});
        if (bus.e_done)      rlog.push_back('{2, cyc, 4'd0});
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic drive(input int who, input logic v, input logic [10:0] x, input logic [9:0] y);
        case (who)
            0: begin bus.p_req_valid = v; bus.p_req_x = x; bus.p_req_y = y; end
            1: begin bus.s_req_valid = v; bus.s_req_x = x; bus.s_req_y = y; end
            default: begin bus.e_req_valid = v; bus.e_req_x = x; bus.e_req_y = y; end
        endcase
    endtask

    function automatic rsp_t get_r(input int idx);
        rsp_t r;
        r.kind = -1;
        r.cyc  = -1;
        r.st   = 4'd0;
        if (idx < rlog.size()) r = rlog[idx];
        return r;
    endfunction

    task automatic wait_phase(input int ph);
        int k;
        k = 0;
        while (tb_phase != 6'(ph) && k < 200) begin step(); k++; end
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int   k, g, n0, held_bad, who;
        rsp_t r;
        who = v.sh ? 1 : 0;
        wait_phase(v.ph);
        drive(who, 1'b1, v.x, v.y);
        step();
        drive(who, 1'b0, v.x, v.y);
        check({tag, "_accepted"}, v.sh ? bus.s_req_ready : bus.p_req_ready, 0);
        n0 = rlog.size();
        k  = 1;
        while (!(eng_x == v.x && eng_y == v.y) && k < 200) begin step(); k++; end
        check({tag, "_grant_wait"}, k - 1, v.wt);
        check({tag, "_grant_mode"}, {eng_game_state, eng_id}, {1'b0, !v.sh});
        g = cyc;
        held_bad = 0;
        k = 0;
        while (rlog.size() == n0 && k < 200) begin
            step();
            k++;
            if (k <= 50 && (eng_x != v.x || eng_y != v.y)) held_bad++;
        end
        check({tag, "_held"}, held_bad, 0);
        r = get_r(n0);
        check({tag, "_rsp_lat"}, r.cyc - g, 52);
        check({tag, "_rsp_kind"}, r.kind, who);
        check({tag, "_rsp_states"}, r.st, v.st);
        repeat (5) step();
        check({tag, "_one_pulse"}, rlog.size() - n0, 1);
    endtask

    vec_t vt[4];

    initial begin
        int   bad, k, n0, g, gcount;
        int   gcyc[3];
        logic gid[3];
        rsp_t r;
        vec_t post;

        vt[0] = '{1'b0, 11'h040, 10'h1F0, 10, 4'h8, 40};
        vt[1] = '{1'b1, 11'h00A, 10'h003,  0, 4'h9, 50};
        vt[2] = '{1'b0, 11'h123, 10'h0F5, 50, 4'hE, 51};
        vt[3] = '{1'b1, 11'h7FE, 10'h001, 49, 4'hF,  1};
        post  = '{1'b0, 11'h0AA, 10'h055,  0, 4'h7, 50};

        drive(0, 1'b0, 11'h0, 10'h0);
        drive(1, 1'b0, 11'h0, 10'h0);
        drive(2, 1'b0, 11'h0, 10'h0);
        repeat (3) step();
        check("rst_ready", {bus.p_req_ready, bus.s_req_ready, bus.e_req_ready}, 3'b111);
        check("rst_eng", {eng_game_state, eng_id, eng_x, eng_y}, {1'b0, 1'b0, 11'h7FF, 10'h3FF});
        check("rst_alive", cube_alive, {NUM_CUBES{1'b1}});
        check("rst_pulses", {bus.p_rsp_valid, bus.s_rsp_valid, bus.e_done}, 3'b000);
        check("rst_states", {bus.p_rsp_states, bus.s_rsp_states}, 8'h00);
        rst_n = 1'b1;

        bad = 0;
        repeat (200) begin
            step();
            if (eng_x !== 11'h7FF || eng_y !== 10'h3FF || eng_game_state !== 1'b0) bad++;
        end
        check("idle_parked", bad, 0);
        check("idle_no_pulses", rlog.size(), 0);
        check("idle_alive", cube_alive, {NUM_CUBES{1'b1}});

        for (int i = 0; i < 4; i++) run_job(vt[i], $sformatf("vec%0d", i));

        // Both collision requesters held busy: grants must alternate.
        n0 = rlog.size();
        wait_phase(5);
        drive(0, 1'b1, 11'h105, 10'h013);
        drive(1, 1'b1, 11'h20C, 10'h021);
        gcount = 0;
        k = 0;
        while (gcount < 3 && k < 300) begin
            step();
            k++;
            if (tb_phase == 6'd0 && !(eng_x == 11'h7FF && eng_y == 10'h3FF)) begin
                gid[gcount]  = eng_id;
                gcyc[gcount] = cyc;
                gcount++;
            end
        end
        drive(0, 1'b0, 11'h0, 10'h0);
        drive(1, 1'b0, 11'h0, 10'h0);
        check("alt_grants", gcount, 3);
        check("alt_ids", {gid[0], gid[1], gid[2]}, 3'b101);
        check("alt_spacing", {16'(gcyc[1] - gcyc[0]), 16'(gcyc[2] - gcyc[1])}, {16'd51, 16'd51});
        k = 0;
        while (rlog.size() < n0 + 3 && k < 300) begin step(); k++; end
        r = get_r(n0);
        check("alt_rsp0", {8'(r.kind), 16'(r.cyc - gcyc[0]), r.st}, {8'd0, 16'd52, 4'hE});
        r = get_r(n0 + 1);
        check("alt_rsp1", {8'(r.kind), 16'(r.cyc - gcyc[1]), r.st}, {8'd1, 16'd52, 4'hD});
        r = get_r(n0 + 2);
        check("alt_rsp2", {8'(r.kind), 16'(r.cyc - gcyc[2]), r.st}, {8'd0, 16'd52, 4'hE});
        repeat (150) step();

        // Explode competes with both collision requesters and must win.
        wait_phase(20);
        n0 = rlog.size();
        drive(0, 1'b1, 11'h111, 10'h002);
        drive(1, 1'b1, 11'h333, 10'h004);
        drive(2, 1'b1, 11'h0C0, 10'h240);
        step();
        drive(0, 1'b0, 11'h0, 10'h0);
        drive(1, 1'b0, 11'h0, 10'h0);
        drive(2, 1'b0, 11'h0, 10'h0);
        wait_phase(0);
        check("exp_grant", {eng_game_state, eng_id, eng_x, eng_y}, {1'b1, 1'b0, 11'h0C0, 10'h240});
        g = cyc;
        k = 0;
        while (rlog.size() < n0 + 3 && k < 300) begin step(); k++; end
        r = get_r(n0);
        check("exp_done", {8'(r.kind), 16'(r.cyc - g)}, {8'd2, 16'd52});
        r = get_r(n0 + 1);
        check("exp_then_p", {8'(r.kind), r.st}, {8'd0, 4'hB});
        r = get_r(n0 + 2);
        check("exp_then_s", {8'(r.kind), r.st}, {8'd1, 4'h7});
        repeat (5) step();
        check("exp_alive", cube_alive, 50'h3F3FFFFFFFFFF);

        // Second blast elsewhere; the engine reports cubes 42/43 alive again, bitmap must not.
        wait_phase(5);
        n0 = rlog.size();
        drive(2, 1'b1, 11'h000, 10'h000);
        step();
        drive(2, 1'b0, 11'h0, 10'h0);
        k = 0;
        while (rlog.size() == n0 && k < 200) begin step(); k++; end
        r = get_r(n0);
        check("exp2_kind", r.kind, 2);
        step();
        check("exp2_alive", cube_alive, 50'h3F3FFFFFFFFFE);

        // Reset with an explode in flight and both collision slots pending.
        wait_phase(30);
        drive(0, 1'b1, 11'h0AA, 10'h055);
        drive(1, 1'b1, 11'h0BB, 10'h066);
        drive(2, 1'b1, 11'h100, 10'h100);
        step();
        drive(0, 1'b0, 11'h0, 10'h0);
        drive(1, 1'b0, 11'h0, 10'h0);
        drive(2, 1'b0, 11'h0, 10'h0);
        k = 0;
        while (eng_game_state != 1'b1 && k < 100) begin step(); k++; end
        wait_phase(25);
        n0 = rlog.size();
        rst_n = 1'b0;
        repeat (3) step();
        check("mid_rst_ready", {bus.p_req_ready, bus.s_req_ready, bus.e_req_ready}, 3'b111);
        check("mid_rst_pulses", {bus.p_rsp_valid, bus.s_rsp_valid, bus.e_done}, 3'b000);
        rst_n = 1'b1;
        bad = 0;
        repeat (150) begin
            step();
            if (eng_x !== 11'h7FF || eng_y !== 10'h3FF || eng_game_state !== 1'b0) bad++;
        end
        check("post_rst_parked", bad, 0);
        check("post_rst_no_rsp", rlog.size() - n0, 0);
        check("post_rst_alive", cube_alive, {NUM_CUBES{1'b1}});
        check("post_rst_states", {bus.p_rsp_states, bus.s_rsp_states}, 8'h00);
        run_job(post, "post_rst");

        check("eng_hold", hold_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
